// File: rtl/abacus_pkg.sv
// Shared definitions for the multi-lane shared-counter CAM.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// Holds the request opcode enum, the controller state enum and the default
// values of the block parameters.
package abacus_pkg;

    localparam int DEF_N_ENTRY = 16;
    localparam int DEF_N_BANK  = 16;
    localparam int DEF_CNT_W   = 8;
    localparam int DEF_LANES   = 4;
    localparam int DEF_THRESH  = 200;

    typedef enum logic [1:0] {
        OP_SEARCH    = 2'd0,
        OP_INC_IDX   = 2'd1,
        OP_CLEAR_ALL = 2'd2,
        OP_RSVD      = 2'd3
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_INC  = 2'd2,
        ST_CLR  = 2'd3
    } state_e;

endpackage

// File: rtl/count_cam_lane_match.sv
// One scan group of the count CAM: LANES-wide equality compare against a key.
// Latency: purely combinational.
// Backpressure: none; evaluated every cycle.
//
// Ports: lane_cnt - LANES packed counters, lane 0 in the low bits
//        key      - value to match
//        match    - at least one lane equals key
//        offset   - lowest matching lane (0 when no match)
module count_cam_lane_match #(
    parameter int LANES = 4,
    parameter int CNT_W = 8,
    parameter int OFF_W = (LANES > 1) ? $clog2(LANES) : 1
) (
    input  logic [LANES*CNT_W-1:0] lane_cnt,
    input  logic [CNT_W-1:0]       key,
    output logic                   match,
    output logic [OFF_W-1:0]       offset
);

    // Walk from the top lane down so the lowest matching lane is the one
    // left standing.
    always_comb begin
        match  = 1'b0;
        offset = '0;
        for (int l = LANES - 1; l >= 0; l--) begin
            if (lane_cnt[l*CNT_W +: CNT_W] == key) begin
                match  = 1'b1;
                offset = OFF_W'(l);
            end
        end
    end

endmodule

// File: rtl/multi_lane_count_cam.sv
// Shared-counter CAM: SEARCH by count value, INC_IDX by entry, CLEAR_ALL.
// Latency: SEARCH hit in group k -> 2+k cycles, miss -> 1+G; other ops 2 cycles.
// Backpressure: req_ready_o is high only in IDLE; one request in flight.
//
// Ports: clk_i/rst_i (sync active-high), req_valid_i/req_ready_o handshake,
//        req_op_i/req_cnt_i/req_idx_i/req_bank_i request fields,
//        rsp_valid_o pulse with rsp_hit_o/rsp_idx_o/rsp_cnt_o (held between
//        pulses), alert_o threshold pulse.
// Build option: define ABACUS_CNT_ALERT_EN to enable the threshold alert;
//        without it alert_o is tied low.
module multi_lane_count_cam
    import abacus_pkg::*;
#(
    parameter int N_ENTRY = DEF_N_ENTRY,
    parameter int N_BANK  = DEF_N_BANK,
    parameter int CNT_W   = DEF_CNT_W,
    parameter int LANES   = DEF_LANES,
    parameter int THRESH  = DEF_THRESH
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       req_valid_i,
    output logic                       req_ready_o,
    input  logic [1:0]                 req_op_i,
    input  logic [CNT_W-1:0]           req_cnt_i,
    input  logic [$clog2(N_ENTRY)-1:0] req_idx_i,
    input  logic [$clog2(N_BANK)-1:0]  req_bank_i,
    output logic                       rsp_valid_o,
    output logic                       rsp_hit_o,
    output logic [$clog2(N_ENTRY)-1:0] rsp_idx_o,
    output logic [CNT_W-1:0]           rsp_cnt_o,
    output logic                       alert_o
);

    localparam int IDX_W  = $clog2(N_ENTRY);
    localparam int BANK_W = $clog2(N_BANK);
    localparam int G      = N_ENTRY / LANES;
    localparam int OFF_W  = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int GRP_W  = (G > 1) ? $clog2(G) : 1;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    state_e              state_q, state_d;
    op_e                 op_q;
    logic [CNT_W-1:0]    key_q;
    logic [IDX_W-1:0]    idx_q;
    logic [BANK_W-1:0]   bank_q;
    logic [GRP_W-1:0]    grp_q;

    logic [CNT_W-1:0]    cnt_q [N_ENTRY];
    logic [N_BANK-1:0]   vec_q [N_ENTRY];

    logic                accept;
    logic                last_grp;
    logic [IDX_W-1:0]    grp_base;
    logic [IDX_W-1:0]    hit_idx;
    logic [N_BANK-1:0]   bank_mask;
    logic [LANES*CNT_W-1:0] lane_cnt;
    logic                lane_match;
    logic [OFF_W-1:0]    lane_off;

    logic                tbl_wr;
    logic                tbl_clr;
    logic [IDX_W-1:0]    wr_idx;
    logic [CNT_W-1:0]    wr_cnt;
    logic [N_BANK-1:0]   wr_vec;
    logic                rsp_fire;
    logic                rsp_hit_d;
    logic [IDX_W-1:0]    rsp_idx_d;
    logic [CNT_W-1:0]    rsp_cnt_d;

    assign req_ready_o = (state_q == ST_IDLE);
    assign accept      = req_valid_i && req_ready_o;
    assign last_grp    = (grp_q == GRP_W'(G - 1));
    assign grp_base    = IDX_W'(int'(grp_q) * LANES);
    assign hit_idx     = grp_base + IDX_W'(lane_off);
    assign bank_mask   = {{(N_BANK-1){1'b0}}, 1'b1} << bank_q;

    always_comb begin
        lane_cnt = '0;
        for (int l = 0; l < LANES; l++) begin
            lane_cnt[l*CNT_W +: CNT_W] = cnt_q[grp_base + IDX_W'(l)];
        end
    end

    count_cam_lane_match #(
        .LANES (LANES),
        .CNT_W (CNT_W),
        .OFF_W (OFF_W)
    ) u_lane_match (
        .lane_cnt (lane_cnt),
        .key      (key_q),
        .match    (lane_match),
        .offset   (lane_off)
    );

    // State register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = ST_IDLE;
        case (state_q)
            ST_IDLE: begin
                if (req_valid_i) begin
                    case (op_e'(req_op_i))
                        OP_SEARCH:  state_d = ST_SCAN;
                        OP_INC_IDX: state_d = ST_INC;
                        default:    state_d = ST_CLR;  // CLEAR_ALL and reserved
                    endcase
                end
            end
            ST_SCAN: state_d = (lane_match || last_grp) ? ST_IDLE : ST_SCAN;
            default: state_d = ST_IDLE;
        endcase
    end

    // Output / table-update decode
    always_comb begin
        tbl_wr    = 1'b0;
        tbl_clr   = 1'b0;
        wr_idx    = idx_q;
        wr_cnt    = '0;
        wr_vec    = '0;
        rsp_fire  = 1'b0;
        rsp_hit_d = 1'b0;
        rsp_idx_d = '0;
        rsp_cnt_d = '0;
        case (state_q)
            ST_SCAN: begin
                if (lane_match) begin
                    tbl_wr    = 1'b1;
                    wr_idx    = hit_idx;
                    wr_cnt    = sat_inc(key_q);
                    wr_vec    = vec_q[hit_idx] | bank_mask;
                    rsp_fire  = 1'b1;
                    rsp_hit_d = 1'b1;
                    rsp_idx_d = hit_idx;
                    rsp_cnt_d = wr_cnt;
                end else if (last_grp) begin
                    rsp_fire = 1'b1;
                end
            end
            ST_INC: begin
                tbl_wr = 1'b1;
                wr_idx = idx_q;
                // A repeat hit from the same bank closes the round: the
                // shared count advances and the sharing vector restarts.
                if (vec_q[idx_q][bank_q]) begin
                    wr_cnt = sat_inc(cnt_q[idx_q]);
                    wr_vec = bank_mask;
                end else begin
                    wr_cnt = cnt_q[idx_q];
                    wr_vec = vec_q[idx_q] | bank_mask;
                end
                rsp_fire  = 1'b1;
                rsp_hit_d = 1'b1;
                rsp_idx_d = idx_q;
                rsp_cnt_d = wr_cnt;
            end
            ST_CLR: begin
                // Reserved opcode shares this state but leaves the table alone.
                tbl_clr  = (op_q == OP_CLEAR_ALL);
                rsp_fire = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            op_q   <= OP_SEARCH;
            key_q  <= '0;
            idx_q  <= '0;
            bank_q <= '0;
            grp_q  <= '0;
        end else if (accept) begin
            op_q   <= op_e'(req_op_i);
            key_q  <= req_cnt_i;
            idx_q  <= req_idx_i;
            bank_q <= req_bank_i;
            grp_q  <= '0;
        end else if (state_q == ST_SCAN) begin
            grp_q  <= grp_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || tbl_clr) begin
            for (int i = 0; i < N_ENTRY; i++) begin
                cnt_q[i] <= '0;
                vec_q[i] <= '0;
            end
        end else if (tbl_wr) begin
            cnt_q[wr_idx] <= wr_cnt;
            vec_q[wr_idx] <= wr_vec;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rsp_valid_o <= 1'b0;
            rsp_hit_o   <= 1'b0;
            rsp_idx_o   <= '0;
            rsp_cnt_o   <= '0;
        end else begin
            rsp_valid_o <= rsp_fire;
            if (rsp_fire) begin
                rsp_hit_o <= rsp_hit_d;
                rsp_idx_o <= rsp_idx_d;
                rsp_cnt_o <= rsp_cnt_d;
            end
        end
    end

`ifdef ABACUS_CNT_ALERT_EN
    logic alert_q;

    // tbl_wr is only raised on a SEARCH hit or INC_IDX, both response cycles.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            alert_q <= 1'b0;
        end else begin
            alert_q <= tbl_wr && (int'(wr_cnt) >= THRESH);
        end
    end

    assign alert_o = alert_q;
`else
    assign alert_o = 1'b0;
`endif

endmodule

// File: tb/tb_multi_lane_count_cam.sv
module tb_multi_lane_count_cam;

`ifdef ABACUS_CNT_ALERT_EN
    localparam int THR      = 4;
    localparam bit ALERT_ON = 1'b1;
`else
    localparam int THR      = 200;
    localparam bit ALERT_ON = 1'b0;
`endif
    localparam int NE   = 16;
    localparam int LN   = 4;
    localparam int MAXC = 255;

    logic       clk_i = 1'b0;
    logic       rst_i;
    logic       req_valid_i;
    logic       req_ready_o;
    logic [1:0] req_op_i;
    logic [7:0] req_cnt_i;
    logic [3:0] req_idx_i;
    logic [3:0] req_bank_i;
    logic       rsp_valid_o;
    logic       rsp_hit_o;
    logic [3:0] rsp_idx_o;
    logic [7:0] rsp_cnt_o;
    logic       alert_o;

    int n_checks = 0;
    int n_fail   = 0;

    int          m_cnt [NE];
    logic [15:0] m_vec [NE];

    multi_lane_count_cam #(
        .N_ENTRY (16), .N_BANK (16), .CNT_W (8), .LANES (4), .THRESH (THR)
    ) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .req_valid_i (req_valid_i),
        .req_ready_o (req_ready_o),
        .req_op_i    (req_op_i),
        .req_cnt_i   (req_cnt_i),
        .req_idx_i   (req_idx_i),
        .req_bank_i  (req_bank_i),
        .rsp_valid_o (rsp_valid_o),
        .rsp_hit_o   (rsp_hit_o),
        .rsp_idx_o   (rsp_idx_o),
        .rsp_cnt_o   (rsp_cnt_o),
        .alert_o     (alert_o)
    );

    always #5 clk_i = ~clk_i;

    // Reference model: lowest entry holding the key wins; scan cost is one
    // cycle per group of LN entries.
    task automatic model_op(input logic [1:0] op, input logic [7:0] key,
                            input logic [3:0] idx, input logic [3:0] bank,
                            output int e_lat, output logic e_hit,
                            output logic [3:0] e_idx, output logic [7:0] e_cnt,
                            output logic e_alert);
        int found;
        found = -1; e_lat = 1; e_hit = 1'b0; e_idx = '0; e_cnt = '0; e_alert = 1'b0;
        case (op)
            2'd0: begin
                for (int i = 0; i < NE; i++)
                    if (found < 0 && m_cnt[i] == int'(key)) found = i;
                if (found >= 0) begin
                    m_cnt[found] = (int'(key) >= MAXC) ? MAXC : int'(key) + 1;
                    m_vec[found][bank] = 1'b1;
                    e_hit = 1'b1; e_idx = 4'(found); e_cnt = 8'(m_cnt[found]);
                    e_alert = ALERT_ON && (m_cnt[found] >= THR);
                    e_lat = 1 + found / LN;
                end else begin
                    e_lat = NE / LN;
                end
            end
            2'd1: begin
                if (m_vec[idx][bank]) begin
                    m_vec[idx] = '0;
                    if (m_cnt[idx] < MAXC) m_cnt[idx] = m_cnt[idx] + 1;
                end
                m_vec[idx][bank] = 1'b1;
                e_hit = 1'b1; e_idx = idx; e_cnt = 8'(m_cnt[idx]);
                e_alert = ALERT_ON && (m_cnt[idx] >= THR);
            end
            2'd2: begin
                for (int i = 0; i < NE; i++) begin m_cnt[i] = 0; m_vec[i] = '0; end
            end
            default: ;
        endcase
    endtask

    function automatic int table_diff();
        int d = 0;
        for (int i = 0; i < NE; i++)
            if (int'(dut.cnt_q[i]) != m_cnt[i] || dut.vec_q[i] !== m_vec[i]) d++;
        return d;
    endfunction

    // Issue one request (entered and left #1 after a rising edge) and
    // measure the response. lat = edges after the accept edge, -1 on timeout.
    task automatic do_req(input logic [1:0] op, input logic [7:0] key,
                          input logic [3:0] idx, input logic [3:0] bank,
                          output int lat, output logic hit, output logic [3:0] ridx,
                          output logic [7:0] rcnt, output logic ralert,
                          output logic rdy_issue, output int busy_bad);
        req_op_i = op; req_cnt_i = key; req_idx_i = idx; req_bank_i = bank;
        req_valid_i = 1'b1;
        rdy_issue = req_ready_o;
        lat = -1; hit = 1'b0; ridx = '0; rcnt = '0; ralert = 1'b0; busy_bad = 0;
        @(posedge clk_i); #1;
        req_valid_i = 1'b0;
        req_op_i = 2'($urandom); req_cnt_i = 8'($urandom);
        req_idx_i = 4'($urandom); req_bank_i = 4'($urandom);
        if (req_ready_o !== 1'b0 || rsp_valid_o !== 1'b0 || alert_o !== 1'b0) busy_bad++;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk_i); #1;
            if (rsp_valid_o === 1'b1) begin
                lat = c; hit = rsp_hit_o; ridx = rsp_idx_o; rcnt = rsp_cnt_o; ralert = alert_o;
                break;
            end
            if (req_ready_o !== 1'b0 || alert_o !== 1'b0) busy_bad++;
        end
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        repeat (3) @(posedge clk_i);
        #1 rst_i = 1'b0;
        for (int i = 0; i < NE; i++) begin m_cnt[i] = 0; m_vec[i] = '0; end
        @(posedge clk_i); #1;
        n_checks++;
        if ({req_ready_o, rsp_valid_o, rsp_hit_o, alert_o} !== 4'b1000) begin
            n_fail++;
            $display("FAIL reset_flags: ready/valid/hit/alert got %b want 1000",
                     {req_ready_o, rsp_valid_o, rsp_hit_o, alert_o});
        end
        n_checks++;
        if (rsp_idx_o !== 4'd0 || rsp_cnt_o !== 8'd0) begin
            n_fail++; $display("FAIL reset_rsp: idx %0d cnt %0d want 0 0", rsp_idx_o, rsp_cnt_o);
        end
        n_checks++;
        if (table_diff() != 0) begin
            n_fail++; $display("FAIL reset_table: %0d entries differ, want 0", table_diff());
        end
    endtask

    task automatic test_search_first();
        int lat, el, bb; logic h, eh, a, ea, rdy; logic [3:0] ix, ei; logic [7:0] c, ec;
        model_op(2'd0, 8'd0, 4'd0, 4'd3, el, eh, ei, ec, ea);
        do_req(2'd0, 8'd0, 4'd0, 4'd3, lat, h, ix, c, a, rdy, bb);
        n_checks++;
        if (lat != 1 || h !== 1'b1 || ix !== 4'd0 || c !== 8'd1) begin
            n_fail++;
            $display("FAIL search_first: lat %0d hit %b idx %0d cnt %0d want 1 1 0 1", lat, h, ix, c);
        end
        n_checks++;
        if (dut.vec_q[0] !== 16'h0008) begin
            n_fail++; $display("FAIL search_first_vec: got %h want 0008", dut.vec_q[0]);
        end
    endtask

    task automatic test_inc_idx();
        int lat, el, bb; logic h, eh, a, ea, rdy; logic [3:0] ix, ei; logic [7:0] c, ec;
        for (int k = 0; k < 2; k++) begin
            model_op(2'd1, 8'd0, 4'd5, 4'd2, el, eh, ei, ec, ea);
            do_req(2'd1, 8'd0, 4'd5, 4'd2, lat, h, ix, c, a, rdy, bb);
            n_checks++;
            if (lat != 1 || h !== 1'b1 || ix !== 4'd5 || c !== 8'(k) || dut.vec_q[5] !== 16'h0004) begin
                n_fail++;
                $display("FAIL inc_idx_%0d: lat %0d hit %b idx %0d cnt %0d vec %h want 1 1 5 %0d 0004",
                         k, lat, h, ix, c, dut.vec_q[5], k);
            end
        end
    endtask

    task automatic test_scan_latency();
        int lat, el, bb; logic h, eh, a, ea, rdy; logic [3:0] ix, ei; logic [7:0] c, ec;
        model_op(2'd2, 8'd0, 4'd0, 4'd0, el, eh, ei, ec, ea);
        do_req(2'd2, 8'd0, 4'd0, 4'd0, lat, h, ix, c, a, rdy, bb);
        n_checks++;
        if (lat != 1 || h !== 1'b0 || ix !== 4'd0 || c !== 8'd0 || table_diff() != 0) begin
            n_fail++; $display("FAIL clear_all: lat %0d hit %b idx %0d cnt %0d diff %0d", lat, h, ix, c, table_diff());
        end
        for (int k = 0; k < 10; k++) begin
            model_op(2'd1, 8'd0, 4'd13, 4'd0, el, eh, ei, ec, ea);
            do_req(2'd1, 8'd0, 4'd13, 4'd0, lat, h, ix, c, a, rdy, bb);
        end
        model_op(2'd0, 8'd9, 4'd0, 4'd7, el, eh, ei, ec, ea);
        do_req(2'd0, 8'd9, 4'd0, 4'd7, lat, h, ix, c, a, rdy, bb);
        n_checks++;
        if (lat != 4 || h !== 1'b1 || ix !== 4'd13 || c !== 8'd10) begin
            n_fail++; $display("FAIL search_last_group: lat %0d hit %b idx %0d cnt %0d want 4 1 13 10", lat, h, ix, c);
        end
        model_op(2'd0, 8'd77, 4'd0, 4'd1, el, eh, ei, ec, ea);
        do_req(2'd0, 8'd77, 4'd0, 4'd1, lat, h, ix, c, a, rdy, bb);
        n_checks++;
        if (lat != 4 || h !== 1'b0 || ix !== 4'd0 || c !== 8'd0 || table_diff() != 0) begin
            n_fail++; $display("FAIL search_miss: lat %0d hit %b idx %0d cnt %0d diff %0d want 4 0 0 0 0", lat, h, ix, c, table_diff());
        end
        model_op(2'd3, 8'd10, 4'd13, 4'd5, el, eh, ei, ec, ea);
        do_req(2'd3, 8'd10, 4'd13, 4'd5, lat, h, ix, c, a, rdy, bb);
        n_checks++;
        if (lat != 1 || h !== 1'b0 || c !== 8'd0 || table_diff() != 0) begin
            n_fail++; $display("FAIL reserved_op: lat %0d hit %b cnt %0d diff %0d want 1 0 0 0", lat, h, c, table_diff());
        end
    endtask

    task automatic test_saturation();
        int lat, el, bb, bad; logic h, eh, a, ea, rdy; logic [3:0] ix, ei; logic [7:0] c, ec;
        bad = 0;
        for (int k = 0; k < 258; k++) begin
            model_op(2'd1, 8'd0, 4'd2, 4'd1, el, eh, ei, ec, ea);
            do_req(2'd1, 8'd0, 4'd2, 4'd1, lat, h, ix, c, a, rdy, bb);
            if (c !== ec || a !== ea || lat != 1) bad++;
        end
        n_checks++;
        if (bad != 0) begin
            n_fail++; $display("FAIL sat_ramp: %0d responses off model, want 0", bad);
        end
        n_checks++;
        if (c !== 8'd255 || dut.vec_q[2] !== 16'h0002) begin
            n_fail++; $display("FAIL sat_hold: cnt %0d vec %h want 255 0002", c, dut.vec_q[2]);
        end
    endtask

    task automatic test_alert();
        int lat, el, bb; logic h, eh, a, ea, rdy; logic [3:0] ix, ei; logic [7:0] c, ec;
        model_op(2'd2, 8'd0, 4'd0, 4'd0, el, eh, ei, ec, ea);
        do_req(2'd2, 8'd0, 4'd0, 4'd0, lat, h, ix, c, a, rdy, bb);
        for (int k = 0; k < 5; k++) begin
            model_op(2'd1, 8'd0, 4'd7, 4'd0, el, eh, ei, ec, ea);
            do_req(2'd1, 8'd0, 4'd7, 4'd0, lat, h, ix, c, a, rdy, bb);
            n_checks++;
            if (a !== ((ALERT_ON && k == 4) ? 1'b1 : 1'b0) || c !== 8'(k)) begin
                n_fail++; $display("FAIL alert_step_%0d: alert %b cnt %0d want %b %0d", k, a, c, ALERT_ON && k == 4, k);
            end
        end
        @(posedge clk_i); #1;
        n_checks++;
        if (alert_o !== 1'b0 || rsp_valid_o !== 1'b0 || rsp_cnt_o !== 8'd4) begin
            n_fail++; $display("FAIL alert_pulse: alert %b valid %b cnt %0d want 0 0 4", alert_o, rsp_valid_o, rsp_cnt_o);
        end
    endtask

    task automatic test_reset_mid();
        int lat, el, bb, seen; logic h, eh, a, ea, rdy; logic [3:0] ix, ei; logic [7:0] c, ec;
        for (int e = 0; e < 4; e++)
            for (int k = 0; k < 2; k++) begin
                model_op(2'd1, 8'd0, 4'(e), 4'd0, el, eh, ei, ec, ea);
                do_req(2'd1, 8'd0, 4'(e), 4'd0, lat, h, ix, c, a, rdy, bb);
            end
        // Key 0 now first matches entry 4, which lands in cycle t+2.
        req_op_i = 2'd0; req_cnt_i = 8'd0; req_idx_i = 4'd0; req_bank_i = 4'd9;
        req_valid_i = 1'b1;
        @(posedge clk_i); #1 req_valid_i = 1'b0;
        @(posedge clk_i); #1 rst_i = 1'b1;
        @(posedge clk_i); #1 rst_i = 1'b0;
        for (int i = 0; i < NE; i++) begin m_cnt[i] = 0; m_vec[i] = '0; end
        seen = (rsp_valid_o === 1'b1) ? 1 : 0;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk_i); #1;
            if (rsp_valid_o === 1'b1) seen++;
        end
        n_checks++;
        if (seen != 0) begin
            n_fail++; $display("FAIL reset_abort_rsp: %0d response pulses, want 0", seen);
        end
        n_checks++;
        if (table_diff() != 0 || req_ready_o !== 1'b1) begin
            n_fail++; $display("FAIL reset_abort_state: diff %0d ready %b want 0 1", table_diff(), req_ready_o);
        end
    endtask

    task automatic test_back_to_back_random();
        int lat, el, bb; logic h, eh, a, ea, rdy; logic [3:0] ix, ei; logic [7:0] c, ec;
        logic [1:0] op; logic [7:0] key; logic [3:0] idx, bank; int r;
        for (int n = 0; n < 300; n++) begin
            r = $urandom_range(0, 99);
            op = (r < 45) ? 2'd0 : (r < 88) ? 2'd1 : (r < 94) ? 2'd2 : 2'd3;
            key = ($urandom_range(0, 9) == 0) ? 8'($urandom) : 8'($urandom_range(0, 3));
            idx = 4'($urandom);
            bank = 4'($urandom_range(0, 3));
            model_op(op, key, idx, bank, el, eh, ei, ec, ea);
            do_req(op, key, idx, bank, lat, h, ix, c, a, rdy, bb);
            n_checks++;
            if (lat != el) begin
                n_fail++; $display("FAIL rnd_lat[%0d] op %0d: got %0d want %0d", n, op, lat, el);
            end
            n_checks++;
            if ({h, ix, c} !== {eh, ei, ec}) begin
                n_fail++; $display("FAIL rnd_rsp[%0d] op %0d: hit/idx/cnt %b/%0d/%0d want %b/%0d/%0d",
                                   n, op, h, ix, c, eh, ei, ec);
            end
            n_checks++;
            if (a !== ea) begin
                n_fail++; $display("FAIL rnd_alert[%0d]: got %b want %b", n, a, ea);
            end
            n_checks++;
            if (rdy !== 1'b1 || bb != 0) begin
                n_fail++; $display("FAIL rnd_handshake[%0d]: ready_at_issue %b busy_violations %0d want 1 0", n, rdy, bb);
            end
        end
        n_checks++;
        if (table_diff() != 0) begin
            n_fail++; $display("FAIL rnd_table: %0d entries differ, want 0", table_diff());
        end
    endtask

    initial begin
        rst_i = 1'b1; req_valid_i = 1'b0; req_op_i = '0;
        req_cnt_i = '0; req_idx_i = '0; req_bank_i = '0;
        test_reset();
        test_search_first();
        test_inc_idx();
        test_scan_latency();
        test_saturation();
        test_alert();
        test_back_to_back_random();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
